// File: rtl/apb_frame_sequencer.sv
// Frame sequencer between the UART FIFOs and the APB master port: pops W/R command
// frames from RX, runs one APB transfer per frame and pushes the response into TX.
module apb_frame_sequencer #(
    parameter int unsigned ADDRBITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rxempty,
    input  logic [7:0]          rxdata,
    output logic                rxrd,
    input  logic [ADDRBITS-1:0] txemptyloc,
    output logic [7:0]          txdata,
    output logic                txwr,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [31:0]         paddr,
    output logic [31:0]         pwdata,
    input  logic [31:0]         prdata,
    input  logic                pready,
    input  logic                pslverr,
    output logic                busy,
    output logic                cmderr
);
    localparam logic [7:0] CmdWrite = 8'h57;
    localparam logic [7:0] CmdRead  = 8'h52;
    localparam logic [7:0] RespAck  = 8'h06;
    localparam logic [7:0] RespNak  = 8'h15;

    typedef enum logic [2:0] {
        StIdle, StAddr, StData, StSpace, StSetup, StAccess, StResp
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        pwrite_q, pwrite_d;
    logic        err_q, err_d;
    logic        rxrd_q, rxrd_d;
    logic        txwr_q, txwr_d;
    logic        cmderr_q, cmderr_d;
    logic [7:0]  txdata_q, txdata_d;
    logic [31:0] txfree;
    logic [31:0] need;
    logic        resp_last;

    // Room for the whole response must be reserved before the transfer starts.
    assign txfree    = 32'(txemptyloc);
    assign need      = pwrite_q ? 32'd1 : 32'd5;
    assign resp_last = pwrite_q ? (cnt_q == 3'd0) : (cnt_q == 3'd4);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        pwrite_d = pwrite_q;
        err_d    = err_q;
        txdata_d = txdata_q;
        rxrd_d   = 1'b0;
        txwr_d   = 1'b0;
        cmderr_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rxempty) begin
                    rxrd_d = 1'b1;
                    if (rxdata == CmdWrite || rxdata == CmdRead) begin
                        pwrite_d = (rxdata == CmdWrite);
                        cnt_d    = 3'd0;
                        state_d  = StAddr;
                    end else begin
                        cmderr_d = 1'b1;
                    end
                end
            end
            StAddr: begin
                if (!rxempty) begin
                    rxrd_d  = 1'b1;
                    paddr_d = {paddr_q[23:0], rxdata};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd3) begin
                        cnt_d   = 3'd0;
                        state_d = pwrite_q ? StData : StSpace;
                    end
                end
            end
            StData: begin
                if (!rxempty) begin
                    rxrd_d   = 1'b1;
                    pwdata_d = {pwdata_q[23:0], rxdata};
                    cnt_d    = cnt_q + 3'd1;
                    if (cnt_q == 3'd3) begin
                        cnt_d   = 3'd0;
                        state_d = StSpace;
                    end
                end
            end
            StSpace: begin
                if (txfree >= need) state_d = StSetup;
            end
            StSetup: state_d = StAccess;
            StAccess: begin
                if (pready) begin
                    err_d   = pslverr;
                    rdata_d = pslverr ? 32'hFFFF_FFFF : prdata;
                    cnt_d   = 3'd0;
                    state_d = StResp;
                end
            end
            StResp: begin
                txwr_d = 1'b1;
                case (cnt_q)
                    3'd0:    txdata_d = err_q ? RespNak : RespAck;
                    3'd1:    txdata_d = rdata_q[31:24];
                    3'd2:    txdata_d = rdata_q[23:16];
                    3'd3:    txdata_d = rdata_q[15:8];
                    default: txdata_d = rdata_q[7:0];
                endcase
                cnt_d = cnt_q + 3'd1;
                if (resp_last) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 3'd0;
            paddr_q  <= 32'd0;
            pwdata_q <= 32'd0;
            rdata_q  <= 32'd0;
            pwrite_q <= 1'b0;
            err_q    <= 1'b0;
            txdata_q <= 8'd0;
            rxrd_q   <= 1'b0;
            txwr_q   <= 1'b0;
            cmderr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            pwrite_q <= pwrite_d;
            err_q    <= err_d;
            txdata_q <= txdata_d;
            rxrd_q   <= rxrd_d;
            txwr_q   <= txwr_d;
            cmderr_q <= cmderr_d;
        end
    end

    assign rxrd    = rxrd_q;
    assign txwr    = txwr_q;
    assign cmderr  = cmderr_q;
    assign txdata  = txdata_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
    assign pwrite  = pwrite_q;
    assign psel    = (state_q == StSetup) || (state_q == StAccess);
    assign penable = (state_q == StAccess);
    assign busy    = (state_q != StIdle);
endmodule

// File: tb/tb_apb_frame_sequencer.sv
// Directed bench for apb_frame_sequencer with behavioural RX FIFO, TX FIFO and APB slave.
module tb_apb_frame_sequencer;
    localparam int unsigned ADDRBITS = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                rxempty = 1'b1;
    logic [7:0]          rxdata = 8'h00;
    logic                rxrd;
    logic [ADDRBITS-1:0] txemptyloc = 4'd15;
    logic [7:0]          txdata;
    logic                txwr;
    logic                psel, penable, pwrite;
    logic [31:0]         paddr, pwdata;
    logic [31:0]         prdata = 32'h0;
    logic                pready = 1'b0;
    logic                pslverr = 1'b0;
    logic                busy, cmderr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    bit          stall_en = 1'b0;
    bit          stall_tog = 1'b0;
    int          wait_cyc = 0;
    int          acc_cnt = 0;
    int          rx_pops, rx_first_cyc, tx_first_cyc, tx_last_cyc;
    int          setup_cycles, access_cycles, psel_cycles, setup_cyc, cmderr_cnt;
    logic [31:0] setup_addr = 32'h0, setup_wdata = 32'h0;
    logic        setup_write = 1'b0;
    bit          unstable;

    apb_frame_sequencer #(.ADDRBITS(ADDRBITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxempty   (rxempty),
        .rxdata    (rxdata),
        .rxrd      (rxrd),
        .txemptyloc(txemptyloc),
        .txdata    (txdata),
        .txwr      (txwr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .busy      (busy),
        .cmderr    (cmderr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    // RX FIFO: a pop removes the head within the rxrd cycle; stall mode hides bytes on
    // alternate cycles.
    always @(posedge clk) begin
        #1;
        if (rxrd === 1'b1) begin
            checks++;
            if (rxempty !== 1'b0 || rxq.size() == 0) begin
                errors++;
                $display("FAIL rx_pop_when_empty: rxrd=1 with rxempty=%b at cycle %0d, required no pop",
                         rxempty, cyc);
            end else begin
                void'(rxq.pop_front());
                if (rx_pops == 0) rx_first_cyc = cyc;
                rx_pops++;
            end
        end
        stall_tog = ~stall_tog;
        rxempty = (rxq.size() == 0) || (stall_en && stall_tog);
        rxdata = (rxq.size() != 0) ? rxq[0] : 8'h00;
    end

    // TX FIFO capture and APB slave.
    always @(posedge clk) begin
        #1;
        if (txwr === 1'b1) begin
            txq.push_back(txdata);
            if (tx_first_cyc < 0) tx_first_cyc = cyc;
            tx_last_cyc = cyc;
        end
        if (cmderr === 1'b1) cmderr_cnt++;
        if (psel === 1'b1) begin
            psel_cycles++;
            if (penable !== 1'b1) begin
                setup_cycles++;
                setup_cyc   = cyc;
                setup_addr  = paddr;
                setup_wdata = pwdata;
                setup_write = pwrite;
            end else if (paddr !== setup_addr || pwdata !== setup_wdata ||
                         pwrite !== setup_write) begin
                unstable = 1'b1;
            end
        end
        if (psel === 1'b1 && penable === 1'b1) begin
            access_cycles++;
            pready = (acc_cnt == wait_cyc);
            acc_cnt++;
        end else begin
            pready  = 1'b0;
            acc_cnt = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        txq.delete();
        rx_pops = 0;
        rx_first_cyc = -1;
        tx_first_cyc = -1;
        tx_last_cyc = -1;
        setup_cycles = 0;
        access_cycles = 0;
        psel_cycles = 0;
        setup_cyc = -1;
        cmderr_cnt = 0;
        unstable = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        rxq.push_back(w[31:24]);
        rxq.push_back(w[23:16]);
        rxq.push_back(w[15:8]);
        rxq.push_back(w[7:0]);
    endtask

    task automatic wait_tx(input int n, input int budget);
        for (int k = 0; k < budget && txq.size() < n; k++) tick(1);
    endtask

    function automatic logic [39:0] tx_bytes();
        logic [39:0] v = 40'h0;
        for (int i = 0; i < txq.size(); i++) v = {v[31:0], txq[i]};
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        checks++;
        if ({rxrd, txwr, psel, penable, pwrite, busy, cmderr} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 0000000",
                     {rxrd, txwr, psel, penable, pwrite, busy, cmderr});
        end
        checks++;
        if (paddr !== 32'h0) begin
            errors++;
            $display("FAIL reset_paddr: got %h, required 00000000", paddr);
        end
        checks++;
        if (pwdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_pwdata: got %h, required 00000000", pwdata);
        end
        checks++;
        if (txdata !== 8'h0) begin
            errors++;
            $display("FAIL reset_txdata: got %h, required 00", txdata);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_write();
        clear_logs();
        wait_cyc = 0;
        pslverr = 1'b0;
        rxq.push_back(8'h57);
        push_word(32'h1234_5678);
        push_word(32'hDEAD_BEEF);
        wait_tx(1, 60);
        tick(3);
        checks++;
        if (setup_cycles !== 1 || access_cycles !== 1) begin
            errors++;
            $display("FAIL write_phases: setup=%0d access=%0d, required 1 and 1",
                     setup_cycles, access_cycles);
        end
        checks++;
        if (setup_addr !== 32'h1234_5678 || setup_wdata !== 32'hDEAD_BEEF || setup_write !== 1'b1) begin
            errors++;
            $display("FAIL write_apb: addr=%h wdata=%h pwrite=%b, required 12345678 deadbeef 1",
                     setup_addr, setup_wdata, setup_write);
        end
        checks++;
        if (unstable !== 1'b0) begin
            errors++;
            $display("FAIL write_stable: paddr/pwdata/pwrite changed during ACCESS, required stable");
        end
        checks++;
        if (txq.size() !== 1 || tx_bytes() !== 40'h06) begin
            errors++;
            $display("FAIL write_resp: %0d bytes %h, required 1 byte 06", txq.size(), tx_bytes());
        end
        checks++;
        if (tx_last_cyc - rx_first_cyc + 1 !== 13) begin
            errors++;
            $display("FAIL write_latency: got %0d cycles, required 13",
                     tx_last_cyc - rx_first_cyc + 1);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL write_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_read_wait();
        clear_logs();
        wait_cyc = 3;
        pslverr = 1'b0;
        prdata = 32'hCAFE_F00D;
        rxq.push_back(8'h52);
        push_word(32'h0000_0010);
        wait_tx(5, 80);
        tick(3);
        checks++;
        if (access_cycles !== 4) begin
            errors++;
            $display("FAIL read_access_len: got %0d, required 4", access_cycles);
        end
        checks++;
        if (setup_addr !== 32'h0000_0010 || setup_write !== 1'b0) begin
            errors++;
            $display("FAIL read_apb: addr=%h pwrite=%b, required 00000010 0", setup_addr, setup_write);
        end
        checks++;
        if (txq.size() !== 5 || tx_bytes() !== 40'h06CA_FEF0_0D) begin
            errors++;
            $display("FAIL read_resp: %0d bytes %h, required 5 bytes 06cafef00d",
                     txq.size(), tx_bytes());
        end
        checks++;
        if (tx_last_cyc - tx_first_cyc !== 4) begin
            errors++;
            $display("FAIL read_consecutive: push span %0d, required 4", tx_last_cyc - tx_first_cyc);
        end
        checks++;
        if (tx_last_cyc - rx_first_cyc + 1 !== 16) begin
            errors++;
            $display("FAIL read_latency: got %0d cycles, required 16",
                     tx_last_cyc - rx_first_cyc + 1);
        end
        wait_cyc = 0;
    endtask

    task automatic test_errors();
        clear_logs();
        pslverr = 1'b1;
        prdata = 32'h1357_9BDF;
        rxq.push_back(8'h52);
        push_word(32'h0000_0020);
        wait_tx(5, 60);
        tick(3);
        checks++;
        if (txq.size() !== 5 || tx_bytes() !== 40'h15FF_FFFF_FF) begin
            errors++;
            $display("FAIL read_nak: %0d bytes %h, required 5 bytes 15ffffffff",
                     txq.size(), tx_bytes());
        end
        clear_logs();
        rxq.push_back(8'h57);
        push_word(32'h0000_0030);
        push_word(32'h0000_0000);
        wait_tx(1, 60);
        tick(3);
        checks++;
        if (txq.size() !== 1 || tx_bytes() !== 40'h15) begin
            errors++;
            $display("FAIL write_nak: %0d bytes %h, required 1 byte 15", txq.size(), tx_bytes());
        end
        pslverr = 1'b0;
    endtask

    task automatic test_space();
        int raise_cyc;
        clear_logs();
        prdata = 32'h0102_0304;
        txemptyloc = 4'd4;
        rxq.push_back(8'h52);
        push_word(32'hABCD_EF01);
        tick(20);
        checks++;
        if (psel_cycles !== 0) begin
            errors++;
            $display("FAIL space_hold: psel high for %0d cycles, required 0", psel_cycles);
        end
        txemptyloc = 4'd5;
        raise_cyc = cyc;
        wait_tx(5, 40);
        tick(3);
        checks++;
        if (setup_cyc !== raise_cyc + 1) begin
            errors++;
            $display("FAIL space_setup: SETUP at cycle %0d, required %0d", setup_cyc, raise_cyc + 1);
        end
        checks++;
        if (setup_addr !== 32'hABCD_EF01) begin
            errors++;
            $display("FAIL space_addr: got %h, required abcdef01", setup_addr);
        end
        checks++;
        if (txq.size() !== 5 || tx_bytes() !== 40'h0601_0203_04) begin
            errors++;
            $display("FAIL space_resp: %0d bytes %h, required 5 bytes 0601020304",
                     txq.size(), tx_bytes());
        end
        txemptyloc = 4'd15;
    endtask

    task automatic test_cmderr_stall();
        clear_logs();
        prdata = 32'h55AA_55AA;
        stall_en = 1'b1;
        rxq.push_back(8'h41);
        rxq.push_back(8'h52);
        push_word(32'h0001_0203);
        wait_tx(5, 100);
        tick(3);
        stall_en = 1'b0;
        checks++;
        if (cmderr_cnt !== 1) begin
            errors++;
            $display("FAIL cmderr_count: got %0d pulses, required 1", cmderr_cnt);
        end
        checks++;
        if (rx_pops !== 6) begin
            errors++;
            $display("FAIL stall_pops: got %0d, required 6", rx_pops);
        end
        checks++;
        if (setup_addr !== 32'h0001_0203) begin
            errors++;
            $display("FAIL stall_addr: got %h, required 00010203", setup_addr);
        end
        checks++;
        if (txq.size() !== 5 || tx_bytes() !== 40'h0655_AA55_AA) begin
            errors++;
            $display("FAIL stall_resp: %0d bytes %h, required 5 bytes 0655aa55aa",
                     txq.size(), tx_bytes());
        end
    endtask

    task automatic test_reset_abort();
        clear_logs();
        wait_cyc = 10;
        rxq.push_back(8'h57);
        push_word(32'h0000_0040);
        push_word(32'h1111_2222);
        for (int k = 0; k < 60 && penable !== 1'b1; k++) tick(1);
        checks++;
        if (penable !== 1'b1) begin
            errors++;
            $display("FAIL abort_reach_access: penable=%b, required 1", penable);
        end
        rst = 1'b1;
        tick(1);
        checks++;
        if ({rxrd, txwr, psel, penable, pwrite, busy, cmderr} !== 7'b0 ||
            paddr !== 32'h0 || pwdata !== 32'h0 || txdata !== 8'h0) begin
            errors++;
            $display("FAIL abort_reset_vals: ctrl=%b paddr=%h pwdata=%h txdata=%h, required all 0",
                     {rxrd, txwr, psel, penable, pwrite, busy, cmderr}, paddr, pwdata, txdata);
        end
        rst = 1'b0;
        tick(5);
        checks++;
        if (txq.size() !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_resp: %0d pushes busy=%b, required 0 and 0", txq.size(), busy);
        end
        clear_logs();
        wait_cyc = 0;
        rxq.push_back(8'h57);
        push_word(32'h0000_0044);
        push_word(32'h0000_0099);
        wait_tx(1, 60);
        tick(3);
        checks++;
        if (setup_addr !== 32'h0000_0044 || setup_wdata !== 32'h0000_0099 || setup_write !== 1'b1) begin
            errors++;
            $display("FAIL abort_next_apb: addr=%h wdata=%h pwrite=%b, required 00000044 00000099 1",
                     setup_addr, setup_wdata, setup_write);
        end
        checks++;
        if (txq.size() !== 1 || tx_bytes() !== 40'h06) begin
            errors++;
            $display("FAIL abort_next_resp: %0d bytes %h, required 1 byte 06", txq.size(), tx_bytes());
        end
    endtask

    initial begin
        clear_logs();
        tick(1);
        test_reset();
        test_write();
        test_read_wait();
        test_errors();
        test_space();
        test_cmderr_stall();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
